// File: rtl/strobe_counter_bank.sv
// strobe_counter_bank
// CHANNELS independent WIDTH-bit tick counters. Each channel has its own
// period and periodic/one-shot mode, loaded through one shared write port,
// and produces a registered single-cycle strobe on every period-th tick.
// A write and a tick to the same channel in one cycle: the write wins.
//
// Optional feature macro: STROBE_COUNTER_BANK_PRESCALE_EN
//   defined   -> a shared prescaler gates all channel ticks to once every
//                PRESCALE cycles
//   undefined -> every cycle is a global tick; PRESCALE is ignored
module strobe_counter_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int CH_BITS  = 2,
    parameter int PRESCALE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic                wr_en,
    input  logic [CH_BITS-1:0]  wr_ch,
    input  logic [WIDTH-1:0]    wr_period,
    input  logic                wr_oneshot,
    output logic [CHANNELS-1:0] strobe,
    output logic [CHANNELS-1:0] armed
);

    // Per-channel state
    logic [WIDTH-1:0]    count_r   [CHANNELS];
    logic [WIDTH-1:0]    period_r  [CHANNELS];
    logic [CHANNELS-1:0] oneshot_r;
    logic [CHANNELS-1:0] armed_r;
    logic [CHANNELS-1:0] strobe_r;

    // Next-state values
    logic [WIDTH-1:0]    count_nx_s  [CHANNELS];
    logic [WIDTH-1:0]    period_nx_s [CHANNELS];
    logic [CHANNELS-1:0] oneshot_nx_s;
    logic [CHANNELS-1:0] armed_nx_s;
    logic [CHANNELS-1:0] strobe_nx_s;

    logic [CHANNELS-1:0] wr_sel_s;
    logic                gtick_s;

`ifdef STROBE_COUNTER_BANK_PRESCALE_EN
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0] ps_cnt_r;

    // Global tick fires on the last prescaler state
    always_comb begin
        gtick_s = (ps_cnt_r == PS_W'(PRESCALE - 1));
    end

    // Free-running prescaler 0..PRESCALE-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_cnt_r <= '0;
        end else if (gtick_s) begin
            ps_cnt_r <= '0;
        end else begin
            ps_cnt_r <= ps_cnt_r + PS_W'(1);
        end
    end
`else
    // Prescaler compiled out: every cycle is a global tick
    always_comb begin
        gtick_s = 1'b1;
    end
`endif

    // Decode the write port; out-of-range channel numbers match nothing
    always_comb begin
        wr_sel_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (wr_en && ({1'b0, wr_ch} == (CH_BITS + 1)'(i))) begin
                wr_sel_s[i] = 1'b1;
            end else begin
                wr_sel_s[i] = 1'b0;
            end
        end
    end

    // Per-channel next state: write beats tick, tick advances or completes
    always_comb begin
        oneshot_nx_s = oneshot_r;
        armed_nx_s   = armed_r;
        strobe_nx_s  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            count_nx_s[i]  = count_r[i];
            period_nx_s[i] = period_r[i];
            if (wr_sel_s[i]) begin
                period_nx_s[i]  = wr_period;
                oneshot_nx_s[i] = wr_oneshot;
                count_nx_s[i]   = WIDTH'(1);
                armed_nx_s[i]   = (wr_period != '0);
            end else if (en[i] && armed_r[i] && gtick_s) begin
                if (count_r[i] == period_r[i]) begin
                    strobe_nx_s[i] = 1'b1;
                    count_nx_s[i]  = WIDTH'(1);
                    if (oneshot_r[i]) begin
                        armed_nx_s[i] = 1'b0;
                    end else begin
                        armed_nx_s[i] = armed_r[i];
                    end
                end else begin
                    count_nx_s[i] = count_r[i] + WIDTH'(1);
                end
            end else begin
                count_nx_s[i] = count_r[i];
            end
        end
    end

    // Channel state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                count_r[i]  <= WIDTH'(1);
                period_r[i] <= '0;
            end
            oneshot_r <= '0;
            armed_r   <= '0;
            strobe_r  <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                count_r[i]  <= count_nx_s[i];
                period_r[i] <= period_nx_s[i];
            end
            oneshot_r <= oneshot_nx_s;
            armed_r   <= armed_nx_s;
            strobe_r  <= strobe_nx_s;
        end
    end

    assign strobe = strobe_r;
    assign armed  = armed_r;

endmodule
